// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the vending controller.
//   - coin encodings as seen on coin_in (NOCOIN/NICKEL/DIME/QUARTER)
//   - coin values in cents (5/10/25)
//   - controller state enum (IDLE/COLLECT/VEND)
//   - legal change amounts C0..C20
//   - coin_value(): maps a coin encoding to its value in cents
package vend_pkg;

  localparam logic [1:0] NOCOIN  = 2'b00;
  localparam logic [1:0] NICKEL  = 2'b01;
  localparam logic [1:0] DIME    = 2'b10;
  localparam logic [1:0] QUARTER = 2'b11;

  localparam logic [4:0] VAL_NICKEL  = 5'd5;
  localparam logic [4:0] VAL_DIME    = 5'd10;
  localparam logic [4:0] VAL_QUARTER = 5'd25;

  localparam logic [4:0] C0  = 5'd0;
  localparam logic [4:0] C5  = 5'd5;
  localparam logic [4:0] C10 = 5'd10;
  localparam logic [4:0] C15 = 5'd15;
  localparam logic [4:0] C20 = 5'd20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2
  } state_t;

  function automatic logic [4:0] coin_value(input logic [1:0] coin);
    case (coin)
      NICKEL:  return VAL_NICKEL;
      DIME:    return VAL_DIME;
      QUARTER: return VAL_QUARTER;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_calc.sv
// vend_change_calc: combinational change maker.
// Given a change amount (0/5/10/15/20 cents) and the available nickel and
// dime inventory, picks the coins to pay out using a fixed dime-first
// priority and flags whether exact change is possible.
// Ports:
//   i_change   change amount in cents
//   i_nickels  nickel inventory available
//   i_dimes    dime inventory available
//   o_nickels  nickels to pay (0..4)
//   o_dimes    dimes to pay (0..2)
//   o_ok       exact change can be paid
module vend_change_calc
  import vend_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic [4:0]       i_change,
  input  logic [CNT_W-1:0] i_nickels,
  input  logic [CNT_W-1:0] i_dimes,
  output logic [2:0]       o_nickels,
  output logic [1:0]       o_dimes,
  output logic             o_ok
);

  logic w_n1, w_n2, w_n3, w_n4, w_d1, w_d2;

  assign w_n1 = (i_nickels >= CNT_W'(1));
  assign w_n2 = (i_nickels >= CNT_W'(2));
  assign w_n3 = (i_nickels >= CNT_W'(3));
  assign w_n4 = (i_nickels >= CNT_W'(4));
  assign w_d1 = (i_dimes   >= CNT_W'(1));
  assign w_d2 = (i_dimes   >= CNT_W'(2));

  always_comb begin
    o_nickels = 3'd0;
    o_dimes   = 2'd0;
    o_ok      = 1'b0;
    case (i_change)
      C0: o_ok = 1'b1;
      C5: begin
        o_ok      = w_n1;
        o_nickels = w_n1 ? 3'd1 : 3'd0;
      end
      C10: begin
        if (w_d1) begin
          o_ok = 1'b1; o_dimes = 2'd1;
        end else if (w_n2) begin
          o_ok = 1'b1; o_nickels = 3'd2;
        end
      end
      C15: begin
        if (w_d1 && w_n1) begin
          o_ok = 1'b1; o_dimes = 2'd1; o_nickels = 3'd1;
        end else if (w_n3) begin
          o_ok = 1'b1; o_nickels = 3'd3;
        end
      end
      C20: begin
        if (w_d2) begin
          o_ok = 1'b1; o_dimes = 2'd2;
        end else if (w_d1 && w_n2) begin
          o_ok = 1'b1; o_dimes = 2'd1; o_nickels = 3'd2;
        end else if (w_n4) begin
          o_ok = 1'b1; o_nickels = 3'd4;
        end
      end
      default: o_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin acceptance and vend sequencing controller.
// Accumulates coins into credit, owns the nickel/dime inventory, rejects any
// coin whose resulting change cannot be paid exactly, and issues one vend
// command (change coin counts) over a valid/ready handshake once
// credit >= PRICE.
// Optional build macro: VEND_CTRL_REFILL_EN adds inventory refill inputs.
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   refill_valid/_nickels/_dimes  (VEND_CTRL_REFILL_EN only) inventory refill
//   coin_in                    coin event each cycle (00 none, 01 N, 10 D, 11 Q)
//   vend_ready                 dispense unit accepts the command
//   vend_valid                 vend command pending
//   vend_nickels, vend_dimes   change payload
//   coin_reject                one-cycle pulse, coin returned
//   credit                     current credit in cents
//   nickel_count, dime_count   inventory
//   busy                       high while in VEND
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE        = 60,
  parameter int CNT_W        = 8,
  parameter int INIT_NICKELS = 0,
  parameter int INIT_DIMES   = 0
) (
  input  logic             clock,
  input  logic             reset,
`ifdef VEND_CTRL_REFILL_EN
  input  logic             refill_valid,
  input  logic [3:0]       refill_nickels,
  input  logic [3:0]       refill_dimes,
`endif
  input  logic [1:0]       coin_in,
  input  logic             vend_ready,
  output logic             vend_valid,
  output logic [2:0]       vend_nickels,
  output logic [1:0]       vend_dimes,
  output logic             coin_reject,
  output logic [6:0]       credit,
  output logic [CNT_W-1:0] nickel_count,
  output logic [CNT_W-1:0] dime_count,
  output logic             busy
);

  // Headroom for inventory + coin + refill before saturating back to CNT_W.
  localparam int SUM_W = CNT_W + 2;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] v);
    if (v > SUM_W'({CNT_W{1'b1}})) return {CNT_W{1'b1}};
    return v[CNT_W-1:0];
  endfunction

  state_t           r_state, w_next_state;
  logic [6:0]       r_credit;
  logic [2:0]       r_vend_nickels;
  logic [1:0]       r_vend_dimes;
  logic             r_coin_reject;
  logic [CNT_W-1:0] r_nickel_cnt, r_dime_cnt;

  logic             w_coin_evt, w_is_nickel, w_is_dime;
  logic [7:0]       w_new_credit;
  logic             w_reach;
  logic [4:0]       w_change;
  logic [CNT_W-1:0] w_inv_n, w_inv_d;
  logic [2:0]       w_chg_nickels;
  logic [1:0]       w_chg_dimes;
  logic             w_chg_ok;
  logic             w_accept, w_reject, w_handshake;
  logic             w_vend_valid, w_busy;
  logic [3:0]       w_refill_n, w_refill_d;
  logic [2:0]       w_dec_n;
  logic [1:0]       w_dec_d;
  logic [SUM_W-1:0] w_sum_n, w_sum_d;

  assign w_coin_evt   = (coin_in != NOCOIN);
  assign w_is_nickel  = (coin_in == NICKEL);
  assign w_is_dime    = (coin_in == DIME);
  assign w_new_credit = {1'b0, r_credit} + {3'b000, coin_value(coin_in)};
  assign w_reach      = (w_new_credit >= 8'(PRICE));
  assign w_change     = w_reach ? 5'(w_new_credit - 8'(PRICE)) : 5'd0;

  // The coin being inserted may itself be handed back as change.
  assign w_inv_n = w_is_nickel ? sat_cnt(SUM_W'(r_nickel_cnt) + SUM_W'(1)) : r_nickel_cnt;
  assign w_inv_d = w_is_dime   ? sat_cnt(SUM_W'(r_dime_cnt)   + SUM_W'(1)) : r_dime_cnt;

  vend_change_calc #(.CNT_W(CNT_W)) u_change (
    .i_change  (w_change),
    .i_nickels (w_inv_n),
    .i_dimes   (w_inv_d),
    .o_nickels (w_chg_nickels),
    .o_dimes   (w_chg_dimes),
    .o_ok      (w_chg_ok)
  );

  // Coins below the price are always accepted; coins in VEND never are.
  assign w_accept    = (r_state != VEND) && w_coin_evt && (!w_reach || w_chg_ok);
  assign w_reject    = w_coin_evt && !w_accept;
  assign w_handshake = (r_state == VEND) && vend_ready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, COLLECT: if (w_accept) w_next_state = w_reach ? VEND : COLLECT;
      VEND:          if (vend_ready) w_next_state = IDLE;
      default:       w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_vend_valid = 1'b0;
    w_busy       = 1'b0;
    if (r_state == VEND) begin
      w_vend_valid = 1'b1;
      w_busy       = 1'b1;
    end
  end

  // Credit and payload; the payload is latched on the final coin and held
  // until the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_credit       <= 7'd0;
      r_vend_nickels <= 3'd0;
      r_vend_dimes   <= 2'd0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_coin_reject <= w_reject;
      if (w_accept) begin
        r_credit <= w_new_credit[6:0];
        if (w_reach) begin
          r_vend_nickels <= w_chg_nickels;
          r_vend_dimes   <= w_chg_dimes;
        end
      end else if (w_handshake) begin
        r_credit       <= 7'd0;
        r_vend_nickels <= 3'd0;
        r_vend_dimes   <= 2'd0;
      end
    end
  end

`ifdef VEND_CTRL_REFILL_EN
  assign w_refill_n = refill_valid ? refill_nickels : 4'd0;
  assign w_refill_d = refill_valid ? refill_dimes   : 4'd0;
`else
  assign w_refill_n = 4'd0;
  assign w_refill_d = 4'd0;
`endif

  assign w_dec_n = w_handshake ? r_vend_nickels : 3'd0;
  assign w_dec_d = w_handshake ? r_vend_dimes   : 2'd0;

  // Net inventory change in one sum; payout never exceeds stock because the
  // acceptance check already proved the change payable.
  assign w_sum_n = SUM_W'(r_nickel_cnt) + SUM_W'(w_accept && w_is_nickel)
                 + SUM_W'(w_refill_n) - SUM_W'(w_dec_n);
  assign w_sum_d = SUM_W'(r_dime_cnt) + SUM_W'(w_accept && w_is_dime)
                 + SUM_W'(w_refill_d) - SUM_W'(w_dec_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_nickel_cnt <= CNT_W'(INIT_NICKELS);
      r_dime_cnt   <= CNT_W'(INIT_DIMES);
    end else begin
      r_nickel_cnt <= sat_cnt(w_sum_n);
      r_dime_cnt   <= sat_cnt(w_sum_d);
    end
  end

  assign vend_valid   = w_vend_valid;
  assign busy         = w_busy;
  assign vend_nickels = r_vend_nickels;
  assign vend_dimes   = r_vend_dimes;
  assign coin_reject  = r_coin_reject;
  assign credit       = r_credit;
  assign nickel_count = r_nickel_cnt;
  assign dime_count   = r_dime_cnt;

endmodule
